// File: rtl/acc_pkg.sv
// Shared types and helpers for the output accumulator: default element widths,
// accumulator type, drain state enum and the output saturation function.
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 8
`endif
`ifndef ACC_BIN_LEN
`define ACC_BIN_LEN 12
`endif
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 2
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 2
`endif

package acc_pkg;

  localparam int ACC_BIN_LEN_DEF = `ACC_BIN_LEN;

  typedef logic signed [ACC_BIN_LEN_DEF-1:0] acc_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } acc_state_e;

  // Clamp a sign-extended value into the signed range of an out_bits-wide word.
  // Working at 64 bits lets one function serve any accumulator/output width pair.
  function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] v,
                                                    input int unsigned out_bits);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_bits - 1));
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/acc_row_saturate.sv
// Combinational clamp of one accumulator row (W x ACC_BIN_LEN) down to
// W x OUT_BIN_LEN signed output elements.
module acc_row_saturate
  import acc_pkg::*;
#(
  parameter int OUT_BIN_LEN  = `OUT_BIN_LEN,
  parameter int ACC_BIN_LEN  = `ACC_BIN_LEN,
  parameter int OUTPUT_WIDTH = `OUTPUT_WIDTH
) (
  input  logic [OUTPUT_WIDTH*ACC_BIN_LEN-1:0] i_row,
  output logic [OUTPUT_WIDTH*OUT_BIN_LEN-1:0] o_row
);

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  // registers elsewhere use '<=' so every flop samples pre-edge values.
  always_comb begin
    o_row = '0;
    for (int j = 0; j < OUTPUT_WIDTH; j++) begin
      o_row[j*OUT_BIN_LEN +: OUT_BIN_LEN] =
        OUT_BIN_LEN'(sat_to_out(64'($signed(i_row[j*ACC_BIN_LEN +: ACC_BIN_LEN])),
                                OUT_BIN_LEN));
    end
  end

endmodule

// File: rtl/out_accumulator.sv
// Multi-pass output tile accumulator: sums adder-stage tiles in wide registers,
// then drains the finished tile one saturated row per beat.
module out_accumulator
  import acc_pkg::*;
#(
  parameter int OUT_BIN_LEN   = `OUT_BIN_LEN,
  parameter int ACC_BIN_LEN   = `ACC_BIN_LEN,
  parameter int OUTPUT_HEIGHT = `OUTPUT_HEIGHT,
  parameter int OUTPUT_WIDTH  = `OUTPUT_WIDTH,
  localparam int RIDX_W = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            in_valid,
  input  logic                                            in_first,
  input  logic                                            in_last,
  input  logic [OUTPUT_HEIGHT*OUTPUT_WIDTH*OUT_BIN_LEN-1:0] in_vals,
  output logic                                            in_ready,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [OUTPUT_WIDTH*OUT_BIN_LEN-1:0]             out_row,
  output logic [RIDX_W-1:0]                               out_row_idx,
  output logic                                            out_last
);

  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(OUTPUT_HEIGHT - 1);

  acc_state_e                     r_state;
  acc_state_e                     w_state_nxt;
  logic [RIDX_W-1:0]              r_row_idx;
  logic [RIDX_W-1:0]              w_row_idx_nxt;
  logic signed [ACC_BIN_LEN-1:0]  r_acc    [OUTPUT_HEIGHT][OUTPUT_WIDTH];
  logic signed [ACC_BIN_LEN-1:0]  w_in_ext [OUTPUT_HEIGHT][OUTPUT_WIDTH];
  logic [OUTPUT_WIDTH*ACC_BIN_LEN-1:0] w_sel_row;
  logic                           w_accept;
  logic                           w_xfer;

  assign w_accept = in_valid  && (r_state == ACCUM);
  assign w_xfer   = out_ready && (r_state == DRAIN);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    case (r_state)
      ACCUM: begin
        if (w_accept && in_last) begin
          w_state_nxt   = DRAIN;
          w_row_idx_nxt = '0;
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          if (r_row_idx == LAST_ROW) begin
            w_state_nxt   = ACCUM;
            w_row_idx_nxt = '0;
          end else begin
            w_row_idx_nxt = r_row_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = ACCUM;
        w_row_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ACCUM;
      r_row_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_idx_nxt;
    end
  end

  // Sign-extend each incoming element to accumulator width.
  always_comb begin
    w_in_ext = '{default: '0};
    for (int r = 0; r < OUTPUT_HEIGHT; r++) begin
      for (int c = 0; c < OUTPUT_WIDTH; c++) begin
        w_in_ext[r][c] =
          ACC_BIN_LEN'($signed(in_vals[(r*OUTPUT_WIDTH + c)*OUT_BIN_LEN +: OUT_BIN_LEN]));
      end
    end
  end

  // NOTE: the accumulator array is reset on purpose: a non-first pass after
  // reset must add onto zero, and a reset mid-drain must discard the tile.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < OUTPUT_HEIGHT; r++) begin
        for (int c = 0; c < OUTPUT_WIDTH; c++) begin
          r_acc[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < OUTPUT_HEIGHT; r++) begin
        for (int c = 0; c < OUTPUT_WIDTH; c++) begin
          r_acc[r][c] <= in_first ? w_in_ext[r][c] : r_acc[r][c] + w_in_ext[r][c];
        end
      end
    end
  end

  always_comb begin
    w_sel_row = '0;
    for (int c = 0; c < OUTPUT_WIDTH; c++) begin
      w_sel_row[c*ACC_BIN_LEN +: ACC_BIN_LEN] = r_acc[r_row_idx][c];
    end
  end

  acc_row_saturate #(
    .OUT_BIN_LEN  (OUT_BIN_LEN),
    .ACC_BIN_LEN  (ACC_BIN_LEN),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_row_saturate (
    .i_row (w_sel_row),
    .o_row (out_row)
  );

  assign in_ready    = (r_state == ACCUM);
  assign out_valid   = (r_state == DRAIN);
  assign out_last    = (r_state == DRAIN) && (r_row_idx == LAST_ROW);
  assign out_row_idx = r_row_idx;

endmodule

// File: tb/tb_out_accumulator.sv
// Self-checking bench for out_accumulator with a 2x2 tile, 8-bit outputs and
// 12-bit accumulators: table vectors, corner sequences and random passes.
module tb_out_accumulator;

  localparam int OB = 8;
  localparam int AB = 12;
  localparam int H  = 2;
  localparam int W  = 2;

  typedef logic [3:0][7:0] tile_t;

  typedef struct packed {
    tile_t a;
    tile_t b;
    logic  two_beats;
    tile_t exp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_first;
  logic          in_last;
  logic [31:0]   in_vals;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_row;
  logic [0:0]    out_row_idx;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;
  int model [4];

  out_accumulator #(
    .OUT_BIN_LEN   (OB),
    .ACC_BIN_LEN   (AB),
    .OUTPUT_HEIGHT (H),
    .OUTPUT_WIDTH  (W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_vals     (in_vals),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic tile_t pk(input int e0, input int e1, input int e2, input int e3);
    tile_t t;
    t[0] = e0[7:0];
    t[1] = e1[7:0];
    t[2] = e2[7:0];
    t[3] = e3[7:0];
    return t;
  endfunction

  function automatic int wrap12(input int x);
    int m;
    m = x % 4096;
    if (m < 0)     m += 4096;
    if (m >= 2048) m -= 4096;
    return m;
  endfunction

  function automatic int sat8(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic tile_t model_expect();
    return pk(sat8(model[0]), sat8(model[1]), sat8(model[2]), sat8(model[3]));
  endfunction

  task automatic send(input tile_t v, input bit f, input bit l);
    @(negedge clock);
    check("send.in_ready", int'(in_ready), 1);
    in_vals  = v;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    for (int i = 0; i < 4; i++)
      model[i] = wrap12((f ? 0 : model[i]) + int'($signed(v[i])));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input tile_t exp, input bit rand_ready, input string name);
    int row = 0;
    int cyc = 0;
    logic signed [7:0] e;
    while (row < 2 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      check({name, ".out_valid"}, int'(out_valid), 1);
      check({name, ".in_ready"}, int'(in_ready), 0);
      check({name, ".row_idx"}, int'(out_row_idx), row);
      check({name, ".out_last"}, int'(out_last), (row == 1) ? 1 : 0);
      for (int c = 0; c < 2; c++) begin
        e = out_row[c*8 +: 8];
        check({name, ".elem"}, int'(e), int'($signed(exp[row*2 + c])));
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clock);
      if (out_ready) row++;
    end
    check({name, ".drain_budget"}, row, 2);
    @(negedge clock);
    out_ready = 1'b1;
    check({name, ".in_ready_after"}, int'(in_ready), 1);
    check({name, ".out_valid_after"}, int'(out_valid), 0);
  endtask

  vec_t tbl [3];

  initial begin
    tbl[0] = '{a: pk(10, 10, 10, 10), b: pk(20, 20, 20, 20), two_beats: 1'b1,
               exp: pk(30, 30, 30, 30)};
    tbl[1] = '{a: pk(100, -100, 100, -100), b: pk(100, -100, 100, -100), two_beats: 1'b1,
               exp: pk(127, -128, 127, -128)};
    tbl[2] = '{a: pk(5, -3, 5, -3), b: pk(0, 0, 0, 0), two_beats: 1'b0,
               exp: pk(5, -3, 5, -3)};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_vals   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 0;

    #12;
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.out_last", int'(out_last), 0);
    check("reset.row_idx", int'(out_row_idx), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset.in_ready", int'(in_ready), 1);

    // Table-driven tiles
    for (int t = 0; t < 3; t++) begin
      if (tbl[t].two_beats) begin
        send(tbl[t].a, 1'b1, 1'b0);
        send(tbl[t].b, 1'b0, 1'b1);
      end else begin
        send(tbl[t].a, 1'b1, 1'b1);
      end
      drain(tbl[t].exp, 1'b0, $sformatf("tbl%0d", t));
    end

    // Backpressure on row 0 with an in_valid beat that must be ignored
    send(pk(1, 2, 3, 4), 1'b1, 1'b1);
    @(negedge clock);
    out_ready = 1'b0;
    in_vals   = pk(99, 99, 99, 99);
    in_valid  = 1'b1;
    in_first  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp.out_valid", int'(out_valid), 1);
      check("bp.in_ready", int'(in_ready), 0);
      check("bp.row_idx", int'(out_row_idx), 0);
      check("bp.row", int'(out_row), {8'd2, 8'd1});
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    @(negedge clock);
    check("bp.row1_idx", int'(out_row_idx), 1);
    check("bp.row1_last", int'(out_last), 1);
    check("bp.row1", int'(out_row), {8'd4, 8'd3});
    @(negedge clock);
    check("bp.in_ready_after", int'(in_ready), 1);
    send(pk(1, 1, 1, 1), 1'b0, 1'b1);
    drain(pk(2, 3, 4, 5), 1'b0, "bp_followup");

    // Wrap: 17 x 127 = 2159 -> -1937 in 12 bits -> saturates to -128
    for (int k = 0; k < 17; k++)
      send(pk(127, 127, 127, 127), k == 0, k == 16);
    check("wrap.model", model[0], -1937);
    drain(pk(-128, -128, -128, -128), 1'b0, "wrap");

    // Reset after row 0 has been transferred
    send(pk(10, 20, 30, 40), 1'b1, 1'b1);
    @(negedge clock);
    check("rst.row0_valid", int'(out_valid), 1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    #1;
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_last", int'(out_last), 0);
    check("rst.row_idx", int'(out_row_idx), 0);
    @(negedge clock);
    reset_n = 1'b1;
    send(pk(3, 0, 0, -3), 1'b0, 1'b1);
    drain(pk(3, 0, 0, -3), 1'b0, "rst_zero");
    send(pk(1, 1, 1, 1), 1'b1, 1'b1);
    drain(pk(1, 1, 1, 1), 1'b0, "rst_fl");

    // Random passes against the arithmetic model, random consumer stalls
    for (int it = 0; it < 25; it++) begin
      int nb;
      tile_t v;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
        send(v, (b == 0) && ($urandom_range(0, 3) != 0), b == nb - 1);
      end
      drain(model_expect(), 1'b1, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
